packet_framer_ctrl: RTL and testbench
=====================================

Name: packet_framer_ctrl

Overview:
- Sequencing controller for the packet-identifier byte path.
- Consumes one classified symbol per cycle: data byte plus D/K flag.
- Tracks TLP/DLLP packet context across cycles and strips framing symbols (STP, SDP, END, EDB, PAD).
- Emits framed payload beats with sop/eop/kind/error/nullify tags over a valid/ready handshake to the downstream packet buffer, and enforces packet-length rules.

Parameters:
- DLLP_LEN, 6, exact DLLP payload byte count.
- TLP_MIN_LEN, 12, minimum TLP payload bytes.
- TLP_MAX_LEN, 4096, maximum TLP payload bytes.
- CNT_W, 13, width of payload length counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  symbol byte.
- in_dk  in  1  1 = K (control) symbol, 0 = data.
- in_valid  in  1  symbol present.
- in_ready  out  1  symbol accepted when in_valid && in_ready.
- out_data  out  8  payload byte.
- out_valid  out  1  beat present.
- out_ready  in  1  downstream accepts beat.
- out_sop  out  1  first payload byte of packet.
- out_eop  out  1  last payload byte of packet.
- out_kind  out  2  01 = TLP, 10 = DLLP.
- out_err  out  1  packet malformed; valid with out_eop.
- out_null  out  1  TLP ended by EDB; valid with out_eop.
- err_pulse  out  1  one-cycle strobe per detected error event.
- err_count  out  8  saturating error count.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; hold buffer empty; length counter = 0.
  - out_valid = 0; out_data, sop, eop, kind, err, null = 0.
  - err_pulse = 0; err_count = 0.
  - Reset mid-packet discards the held byte and any pending beat.
- Symbol codes, K only:
  - STP 0xFB, SDP 0x5C, END 0xFD, EDB 0xFE, PAD 0xF7.
  - Any other K value is "bad K".
- Handshake:
  - Output is a single register stage.
  - in_ready = !out_valid || out_ready (combinational).
  - Each accepted symbol produces at most one output beat, registered on the next edge.
  - An output beat holds stable while out_valid && !out_ready.
- FSM states: IDLE, IN_TLP, IN_DLLP.
- One-byte hold buffer:
  - Each data byte is held until the next symbol is accepted, because eop is only known once END/EDB arrives.
  - The held byte carries its own sop flag.
  - Length counter counts accepted payload bytes; it saturates at all-ones.
- IDLE:
  - STP -> IN_TLP, length = 0, next data byte gets sop.
  - SDP -> IN_DLLP, same.
  - PAD ignored.
  - Data, END, EDB, bad K -> error event; stay IDLE; no beat.
- IN_TLP / IN_DLLP:
  - Data, hold empty: store byte.
  - Data, hold full: emit held byte as a beat with eop = 0, then store the new byte.
  - PAD: ignored, no state change.
  - END: emit held byte with eop = 1 and err = length-rule violation; go IDLE.
    - DLLP rule: length == DLLP_LEN.
    - TLP rule: TLP_MIN_LEN <= length <= TLP_MAX_LEN.
  - EDB in IN_TLP: emit held byte with eop = 1, null = 1, err = 0; go IDLE.
  - EDB in IN_DLLP: emit held byte with eop = 1, err = 1; go IDLE.
  - STP or SDP: emit held byte with eop = 1, err = 1 (abort); enter the new packet state; length = 0.
  - Bad K: emit held byte with eop = 1, err = 1; go IDLE.
  - Hold empty at END/EDB/STP/SDP/bad K (zero-length packet): no beat emitted; error event only; same state transition.
- Error accounting:
  - Every beat with err = 1, and every no-beat error case, is one error event.
  - Each event gives err_pulse = 1 on the following cycle and err_count += 1.
  - err_count saturates at 255 and does not wrap.
  - Maximum one event per accepted symbol.
- out_kind of each beat is the kind of the packet the byte belongs to; this still applies for the aborted packet when STP/SDP switches kinds.
- in_valid with in_ready = 0: symbol not consumed, no state change.

Test Plan:
- SDP, 6 data bytes 0x01..0x06, END, out_ready = 1:
  - 6 beats; sop on 0x01; eop on 0x06.
  - kind = 10, err = 0, err_count = 0.
- STP, 12 data bytes, EDB:
  - 12 beats, kind = 01; eop + null on 12th byte.
  - err = 0, err_count = 0.
- SDP, 5 data bytes, END:
  - 5th beat has eop = 1, err = 1.
  - err_pulse once; err_count = 1.
- STP, 3 data bytes, SDP, 6 data bytes, END:
  - 3rd beat eop = 1, err = 1, kind = 01.
  - Then 6 DLLP beats clean; err_count = 1 total from the abort (TLP length never checked).
- Backpressure: STP + 12 bytes + END with out_ready toggling 1,0,0,1:
  - in_ready low exactly while out_valid && !out_ready.
  - No byte lost or duplicated; order preserved.
- END in IDLE 300 times:
  - err_count saturates at 255; no beats emitted.
- Reset asserted mid-TLP after 4 bytes, then SDP + 6 bytes + END:
  - No stale beat emitted.
  - Clean DLLP with sop/eop correct.

Source files
------------

// File: rtl/packet_framer_ctrl.sv
// Packet framer: strips STP/SDP/END/EDB/PAD framing from a classified symbol
// stream and emits tagged payload beats through a single-register output stage.
module packet_framer_ctrl #(
  parameter int DLLP_LEN    = 6,
  parameter int TLP_MIN_LEN = 12,
  parameter int TLP_MAX_LEN = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_dk,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_kind,
  output logic       out_err,
  output logic       out_null,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam logic [CNT_W-1:0] DLLP_LEN_C = CNT_W'(DLLP_LEN);
  localparam logic [CNT_W-1:0] TLP_MIN_C  = CNT_W'(TLP_MIN_LEN);
  localparam logic [CNT_W-1:0] TLP_MAX_C  = CNT_W'(TLP_MAX_LEN);

  typedef enum logic [1:0] {IDLE, IN_TLP, IN_DLLP} state_t;

  state_t             state, state_n;
  logic               hold_valid, hold_valid_n;
  logic [7:0]         hold_data, hold_data_n;
  logic               hold_sop, hold_sop_n;
  logic [CNT_W-1:0]   len, len_n;

  logic               acc;
  logic               emit, b_eop, b_err, b_null;
  logic               ev;
  logic               term, term_err, term_null;
  logic               len_ok;
  logic [1:0]         cur_kind;

  // valid/ready: a symbol moves when in_valid && in_ready; a beat moves when
  // out_valid && out_ready and holds stable until then.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign cur_kind = (state == IN_DLLP) ? 2'b10 : 2'b01;
  assign len_ok   = (state == IN_DLLP) ? (len == DLLP_LEN_C)
                                       : ((len >= TLP_MIN_C) && (len <= TLP_MAX_C));

  always_comb begin
    state_n      = state;
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    hold_sop_n   = hold_sop;
    len_n        = len;
    emit         = 1'b0;
    b_eop        = 1'b0;
    b_err        = 1'b0;
    b_null       = 1'b0;
    ev           = 1'b0;
    term         = 1'b0;
    term_err     = 1'b0;
    term_null    = 1'b0;
    if (acc) begin
      if (!in_dk) begin
        if (state == IDLE) begin
          ev = 1'b1;
        end else begin
          // A zero length means this is the first payload byte of the packet.
          emit         = hold_valid;
          hold_valid_n = 1'b1;
          hold_data_n  = in_data;
          hold_sop_n   = (len == '0);
          len_n        = (&len) ? len : len + 1'b1;
        end
      end else begin
        case (in_data)
          K_PAD: ;
          K_STP, K_SDP: begin
            term     = (state != IDLE);
            term_err = 1'b1;
            state_n  = (in_data == K_STP) ? IN_TLP : IN_DLLP;
            len_n    = '0;
          end
          K_END: begin
            if (state == IDLE) ev = 1'b1;
            term     = (state != IDLE);
            term_err = !len_ok;
            state_n  = IDLE;
          end
          K_EDB: begin
            if (state == IDLE) ev = 1'b1;
            term      = (state != IDLE);
            term_err  = (state == IN_DLLP);
            term_null = (state == IN_TLP);
            state_n   = IDLE;
          end
          default: begin
            if (state == IDLE) ev = 1'b1;
            term     = (state != IDLE);
            term_err = 1'b1;
            state_n  = IDLE;
          end
        endcase
        if (term) begin
          hold_valid_n = 1'b0;
          if (hold_valid) begin
            emit   = 1'b1;
            b_eop  = 1'b1;
            b_err  = term_err;
            b_null = term_null;
            ev     = term_err;
          end else begin
            ev = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
      hold_sop   <= 1'b0;
      len        <= '0;
    end else begin
      state      <= state_n;
      hold_valid <= hold_valid_n;
      hold_data  <= hold_data_n;
      hold_sop   <= hold_sop_n;
      len        <= len_n;
    end
  end

  // The beat carries the kind of the packet it belongs to, even on an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_kind  <= 2'b00;
      out_err   <= 1'b0;
      out_null  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= hold_data;
      out_sop   <= hold_sop;
      out_eop   <= b_eop;
      out_kind  <= cur_kind;
      out_err   <= b_err;
      out_null  <= b_null;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= 8'h00;
    end else begin
      err_pulse <= ev;
      if (ev && (err_count != 8'hFF)) err_count <= err_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_packet_framer_ctrl.sv
// Bench for packet_framer_ctrl: directed symbol streams, a packet-level model
// producing expected beats, and a per-cycle compare process.
module tb_packet_framer_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_dk;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] out_kind;
  logic       out_err;
  logic       out_null;
  logic       err_pulse;
  logic [7:0] err_count;

  packet_framer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_dk(in_dk), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_kind(out_kind),
    .out_err(out_err), .out_null(out_null),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // beat = {data, sop, eop, kind, err, null}
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [13:0] beat_log[$];
  logic [7:0]  m_bytes[$];
  int          m_kind;      // 0 idle, 1 TLP, 2 DLLP (matches kind code)
  int          m_errs;
  logic        ev_flag;
  int          n_cmp;
  int          n_fail;
  logic        run_checks;
  logic        bp_mode;
  logic [3:0]  bp_pat;
  int          bp_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // packet-level model
  task automatic m_event();
    ev_flag = 1'b1;
    if (m_errs < 255) m_errs++;
  endtask

  task automatic m_term(input logic err, input logic nul);
    int n;
    n = m_bytes.size();
    if (n == 0) begin
      m_event();
    end else begin
      for (int i = 0; i < n; i++) begin
        logic last;
        last = (i == n - 1);
        exp_q.push_back({m_bytes[i], (i == 0), last, 2'(m_kind), err & last, nul & last});
      end
      if (err) m_event();
    end
    m_bytes.delete();
  endtask

  task automatic model_step(input logic k, input logic [7:0] d);
    int n;
    if (!k) begin
      if (m_kind == 0) m_event();
      else m_bytes.push_back(d);
    end else begin
      case (d)
        8'hF7: ;
        8'hFB, 8'h5C: begin
          if (m_kind != 0) m_term(1'b1, 1'b0);
          m_kind = (d == 8'hFB) ? 1 : 2;
        end
        8'hFD: begin
          if (m_kind == 0) m_event();
          else begin
            n = m_bytes.size();
            if (m_kind == 2) m_term(n != 6, 1'b0);
            else m_term(!(n >= 12 && n <= 4096), 1'b0);
            m_kind = 0;
          end
        end
        8'hFE: begin
          if (m_kind == 0) m_event();
          else begin
            m_term(m_kind == 2, m_kind == 1);
            m_kind = 0;
          end
        end
        default: begin
          if (m_kind == 0) m_event();
          else begin
            m_term(1'b1, 1'b0);
            m_kind = 0;
          end
        end
      endcase
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    obs_q.delete();
    m_bytes.delete();
    m_kind  = 0;
    m_errs  = 0;
    ev_flag = 1'b0;
  endtask

  // downstream ready pattern
  initial begin
    out_ready = 1'b1;
    bp_idx    = 0;
    forever begin
      @(negedge clk);
      out_ready = bp_mode ? bp_pat[bp_idx] : 1'b1;
      bp_idx    = (bp_idx + 1) % 4;
    end
  end

  // compare process: every cycle, away from the active edge
  initial begin
    logic        hold_chk;
    logic [13:0] held;
    logic [13:0] cur;
    logic [13:0] e;
    logic [13:0] o;
    hold_chk = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && run_checks) begin
        cur = {out_data, out_sop, out_eop, out_kind, out_err, out_null};
        chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        chk("err_count", 32'(err_count), 32'(m_errs));
        chk("err_pulse", 32'(err_pulse), 32'(ev_flag));
        ev_flag = 1'b0;
        if (hold_chk) chk("stall_hold", {17'd0, out_valid, cur}, {17'd0, 1'b1, held});
        hold_chk = out_valid && !out_ready;
        held     = cur;
        if (out_valid && out_ready) begin
          obs_q.push_back(cur);
          beat_log.push_back(cur);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          chk("beat", 32'(o), 32'(e));
        end
      end else begin
        hold_chk = 1'b0;
        ev_flag  = 1'b0;
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic k, input logic [7:0] d);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_dk    = k;
    in_data  = d;
    in_valid = 1'b1;
    while (!acc && guard < 100) begin
      #4;
      acc = in_ready;
      @(posedge clk);
      if (acc) model_step(k, d);
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) send(1'b0, first + 8'(i));
  endtask

  initial begin
    int base;
    n_cmp      = 0;
    n_fail     = 0;
    run_checks = 1'b0;
    bp_mode    = 1'b0;
    bp_pat     = 4'b1001;
    in_data    = 8'h00;
    in_dk      = 1'b0;
    in_valid   = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    idle(2);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", {16'd0, out_data, out_sop, out_eop, out_kind, out_err, out_null}, 32'd0);
    chk("rst_err", {23'd0, err_pulse, err_count}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    run_checks = 1'b1;
    idle(1);

    // clean DLLP
    base = beat_log.size();
    send(1'b1, 8'h5C); send_bytes(6, 8'h01); send(1'b1, 8'hFD);
    idle(3);
    chk("t1_beats", 32'(beat_log.size() - base), 32'd6);
    chk("t1_first", 32'(beat_log[base]), 32'({8'h01, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0}));
    chk("t1_last", 32'(beat_log[$]), 32'({8'h06, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0}));
    chk("t1_errs", 32'(err_count), 32'd0);

    // TLP nullified by EDB
    base = beat_log.size();
    send(1'b1, 8'hFB); send_bytes(12, 8'h10); send(1'b1, 8'hFE);
    idle(3);
    chk("t2_beats", 32'(beat_log.size() - base), 32'd12);
    chk("t2_last", 32'(beat_log[$]), 32'({8'h1B, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1}));
    chk("t2_errs", 32'(err_count), 32'd0);

    // short DLLP
    send(1'b1, 8'h5C); send_bytes(5, 8'h21); send(1'b1, 8'hFD);
    idle(3);
    chk("t3_last", 32'(beat_log[$]), 32'({8'h25, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0}));
    chk("t3_errs", 32'(err_count), 32'd1);

    // TLP aborted by SDP, then clean DLLP
    base = beat_log.size();
    send(1'b1, 8'hFB); send_bytes(3, 8'h31);
    send(1'b1, 8'h5C); send_bytes(6, 8'h41); send(1'b1, 8'hFD);
    idle(3);
    chk("t4_beats", 32'(beat_log.size() - base), 32'd9);
    chk("t4_abort", 32'(beat_log[base + 2]), 32'({8'h33, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0}));
    chk("t4_dllp_sop", 32'(beat_log[base + 3]), 32'({8'h41, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0}));
    chk("t4_last", 32'(beat_log[$]), 32'({8'h46, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0}));
    chk("t4_errs", 32'(err_count), 32'd2);

    // backpressure with PAD sprinkled in
    base    = beat_log.size();
    bp_mode = 1'b1;
    send(1'b1, 8'hFB); send_bytes(6, 8'h50); send(1'b1, 8'hF7);
    send_bytes(6, 8'h56); send(1'b1, 8'hFD);
    idle(8);
    bp_mode = 1'b0;
    idle(2);
    chk("t5_beats", 32'(beat_log.size() - base), 32'd12);
    chk("t5_last", 32'(beat_log[$]), 32'({8'h5B, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0}));
    chk("t5_errs", 32'(err_count), 32'd2);

    // error count saturation
    base = beat_log.size();
    for (int i = 0; i < 300; i++) send(1'b1, 8'hFD);
    idle(3);
    chk("t6_beats", 32'(beat_log.size() - base), 32'd0);
    chk("t6_errs", 32'(err_count), 32'd255);

    // reset mid-TLP
    send(1'b1, 8'hFB); send_bytes(4, 8'h61);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_errs", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    base = beat_log.size();
    send(1'b1, 8'h5C); send_bytes(6, 8'h71); send(1'b1, 8'hFD);
    idle(3);
    chk("t7_beats", 32'(beat_log.size() - base), 32'd6);
    chk("t7_first", 32'(beat_log[base]), 32'({8'h71, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0}));
    chk("t7_last", 32'(beat_log[$]), 32'({8'h76, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0}));
    chk("t7_errs", 32'(err_count), 32'd0);

    idle(3);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("obs_left", 32'(obs_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
